// File: rtl/piso_tx_8bit_pkg.sv
// Shared definitions for the 8-bit serial link (transmit and receive sides).
package piso_tx_8bit_pkg;

    // Default word length of the serial link.
    localparam int WIDTH_DEFAULT = 8;

    // Transmitter FSM encoding; one bit is enough for IDLE/SHIFT.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Shift a word one place towards the MSB, filling the LSB with 0.
    function automatic logic [WIDTH_DEFAULT-1:0] shl1(input logic [WIDTH_DEFAULT-1:0] v);
        return {v[WIDTH_DEFAULT-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/piso_tx_8bit_if.sv
// Handshake and serial-line bundle of the PISO transmitter.
interface piso_tx_8bit_if import piso_tx_8bit_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic [WIDTH-1:0] i_D;
    logic             i_valid;
    logic             o_ready;
    logic             o_SD;
    logic             o_SE;
    logic             o_busy;
    logic             o_done;

    // Word source / serial sink side.
    modport master (
        output i_D,
        output i_valid,
        input  o_ready,
        input  o_SD,
        input  o_SE,
        input  o_busy,
        input  o_done
    );

    // Transmitter side.
    modport slave (
        input  i_D,
        input  i_valid,
        output o_ready,
        output o_SD,
        output o_SE,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/piso_tx_8bit.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready
// handshake and sends it MSB first, one bit per clock. A new word can be
// accepted on the last-bit cycle so consecutive words stream without gaps.
module piso_tx_8bit import piso_tx_8bit_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    piso_tx_8bit_if.slave bus
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  C_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_LAST_M1 = CNT_W'(WIDTH - 2);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_shifted;

    assign w_accept  = bus.i_valid & r_ready;
    assign w_last    = (r_state == ST_SHIFT) && (r_cnt == C_LAST);
    assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};

    // FSM, shift register, bit counter and registered handshake/status flags.
    // The shift register is empty in IDLE (the last shift clears it), so its
    // MSB can drive the serial line directly in every state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= bus.i_D;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                        r_ready <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_cnt  <= '0;
                        if (w_accept) begin
                            r_shreg <= bus.i_D;
                            r_ready <= 1'b0;
                        end else begin
                            r_shreg <= w_shifted;
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_shreg <= w_shifted;
                        r_cnt   <= r_cnt + 1'b1;
                        r_ready <= (r_cnt == C_LAST_M1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_SD    = r_shreg[WIDTH-1];
    assign bus.o_SE    = (r_state == ST_SHIFT);
    assign bus.o_busy  = (r_state == ST_SHIFT);
    assign bus.o_done  = r_done;

endmodule

// File: tb/tb_piso_tx_8bit.sv
// Loopback bench: PISO transmitter feeding an 8-bit SIPO receive register.
module tb_piso_tx_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] sipo_q;
    int         n_cmp;
    int         n_fail;

    piso_tx_8bit_if #(.WIDTH(8)) bus ();

    piso_tx_8bit #(.WIDTH(8)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive-side SIPO: shifts the serial line in on every clock, MSB first.
    always @(posedge clk) begin
        if (rst) sipo_q <= 8'h00;
        else     sipo_q <= {sipo_q[6:0], bus.o_SD};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Offer one word, then check its eight serial bits against the
    // hand-written MSB-first stream, the done pulse and the received word.
    task automatic send_word(input string tag, input logic [7:0] word,
                             input logic [7:0] stream, input logic [7:0] rx);
        bus.i_D     = word;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_sd"}, 32'(bus.o_SD), 32'(stream[7-i]));
            chk({tag, "_se_busy_done"}, {29'd0, bus.o_SE, bus.o_busy, bus.o_done}, 32'b110);
            tick();
        end
        chk({tag, "_done"}, {30'd0, bus.o_done, bus.o_SE}, 32'b10);
        chk({tag, "_rx"}, 32'(sipo_q), 32'(rx));
        tick();
        chk({tag, "_done_off"}, 32'(bus.o_done), 32'd0);
    endtask

    logic [15:0] b2b_stream;
    logic [15:0] ign_stream;

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_D     = 8'h00;
        b2b_stream  = 16'b0011110010000001;
        ign_stream  = 16'b0000000011111111;

        // Reset for two cycles, then ten idle cycles.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("idle_rdy_sd_se_busy_done",
                {27'd0, bus.o_ready, bus.o_SD, bus.o_SE, bus.o_busy, bus.o_done}, 32'b10000);
            tick();
        end

        // Single word 0xA5 with ready only on the last-bit cycle.
        bus.i_D     = 8'hA5;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("a5_sd", 32'(bus.o_SD), 32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1} >> (7 - i)) & 32'd1);
            chk("a5_rdy", 32'(bus.o_ready), (i == 7) ? 32'd1 : 32'd0);
            chk("a5_se_busy_done", {29'd0, bus.o_SE, bus.o_busy, bus.o_done}, 32'b110);
            tick();
        end
        chk("a5_done_se", {30'd0, bus.o_done, bus.o_SE}, 32'b10);
        chk("a5_rx", 32'(sipo_q), 32'hA5);
        tick();
        chk("a5_done_off", 32'(bus.o_done), 32'd0);

        // Back-to-back 0x3C then 0x81: 16 contiguous enabled cycles.
        bus.i_D     = 8'h3C;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_sd", 32'(bus.o_SD), 32'(b2b_stream[15-i]));
            chk("b2b_se", 32'(bus.o_SE), 32'd1);
            chk("b2b_done", 32'(bus.o_done), (i == 8) ? 32'd1 : 32'd0);
            if (i == 8) chk("b2b_rx0", 32'(sipo_q), 32'h3C);
            if (i == 7) begin
                chk("b2b_rdy", 32'(bus.o_ready), 32'd1);
                bus.i_D     = 8'h81;
                bus.i_valid = 1'b1;
            end
            if (i == 8) bus.i_valid = 1'b0;
            tick();
        end
        chk("b2b_done2_se", {30'd0, bus.o_done, bus.o_SE}, 32'b10);
        chk("b2b_rx1", 32'(sipo_q), 32'h81);
        tick();

        // Ignored load: 0xFF offered from cycle 2 of an 0x00 word.
        bus.i_D     = 8'h00;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("ign_sd", 32'(bus.o_SD), 32'(ign_stream[15-i]));
            chk("ign_se", 32'(bus.o_SE), 32'd1);
            chk("ign_done", 32'(bus.o_done), (i == 8) ? 32'd1 : 32'd0);
            if (i == 8) chk("ign_rx0", 32'(sipo_q), 32'h00);
            if (i == 1) begin
                bus.i_D     = 8'hFF;
                bus.i_valid = 1'b1;
            end
            if (i == 8) bus.i_valid = 1'b0;
            tick();
        end
        chk("ign_done2_se", {30'd0, bus.o_done, bus.o_SE}, 32'b10);
        chk("ign_rx1", 32'(sipo_q), 32'hFF);
        tick();

        // Reset mid-word after three bits of 0xF0.
        bus.i_D     = 8'hF0;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_sd", 32'(bus.o_SD), 32'd1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_rdy_sd_se_busy_done",
            {27'd0, bus.o_ready, bus.o_SD, bus.o_SE, bus.o_busy, bus.o_done}, 32'b10000);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", 32'(bus.o_done), 32'd0);
        end
        send_word("post_abort_0f", 8'h0F, 8'b00001111, 8'h0F);

        // Boundary patterns: lone 1 on the last and first bit cycle.
        send_word("w01", 8'h01, 8'b00000001, 8'h01);
        send_word("w80", 8'h80, 8'b10000000, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
